// File: rtl/hsem_ahb_biu.sv
// rtl/hsem_ahb_biu.sv - AHB-Lite slave bus interface for the hardware semaphore regfile
module hsem_ahb_biu #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int MID_W    = 4,
  parameter int RD_WAIT  = 0,
  parameter int PRIV_EN  = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [31:0]       haddr,
  input  logic [3:0]        hprot,
  input  logic [MID_W-1:0]  hmaster,
  input  logic [DATA_W-1:0] hwdata,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  input  logic [DATA_W-1:0] ihrdata,
  output logic [DATA_W-1:0] ihwdata,
  output logic              wr_en,
  output logic              rd_en,
  output logic [REG_AW-1:0] reg_addr,
  output logic [MID_W-1:0]  reg_mid
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_CAP  = 3'd2;
  localparam logic [2:0] RD_WT   = 3'd3;
  localparam logic [2:0] RD_DONE = 3'd4;
  localparam logic [2:0] ERR1    = 3'd5;
  localparam logic [2:0] ERR2    = 3'd6;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // One extra bit so NUM_REGS == 2**REG_AW is representable
  localparam logic [REG_AW:0] NUM_REGS_W = (REG_AW+1)'(NUM_REGS);
  localparam logic            HAS_WAIT   = (RD_WAIT > 0);
  // RD_WT counts down from RD_WAIT-1 to 0, giving exactly RD_WAIT cycles
  localparam logic [1:0]      WT_LOAD    = HAS_WAIT ? 2'(RD_WAIT - 1) : 2'd0;
  localparam logic            PRIV_CHK   = (PRIV_EN != 0);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [1:0]        wt_cnt;
  logic              acc;
  logic              illegal;
  logic              bad_size;
  logic              bad_align;
  logic              bad_index;
  logic              bad_priv;
  logic [REG_AW-1:0] index;
  logic              unused_inputs;

  assign index = haddr[REG_AW+1:2];

  // A new address phase is only taken while the previous data phase is completing
  assign acc = hsel & hready & htrans[1] & hreadyout;

  assign bad_size  = (hsize != 3'b010);
  assign bad_align = (haddr[1:0] != 2'b00);
  assign bad_index = ({1'b0, index} >= NUM_REGS_W);
  assign bad_priv  = PRIV_CHK & ~hprot[1];
  assign illegal   = bad_size | bad_align | bad_index | bad_priv;

  // Write data goes straight through; the regfile samples it at the end of the WR cycle
  assign ihwdata = hwdata;

  // Bits of the address-phase bus that carry no meaning for this slave
  assign unused_inputs = ^{htrans[0], haddr[31:REG_AW+2], hprot[3:2], hprot[0]};

  // Next-state: completing states accept a new transfer, read/error states walk their sequence
  always_comb begin
    state_nxt = state;
    case (state)
      RD_CAP: state_nxt = HAS_WAIT ? RD_WT : RD_DONE;
      RD_WT:  state_nxt = (wt_cnt == 2'd0) ? RD_DONE : RD_WT;
      ERR1:   state_nxt = ERR2;
      default: begin
        if (acc) begin
          if (illegal) begin
            state_nxt = ERR1;
          end else if (hwrite) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD_CAP;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Bus response and regfile strobes decoded from the current state
  always_comb begin
    hreadyout = 1'b0;
    hresp     = RESP_OKAY;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE:    hreadyout = 1'b1;
      WR: begin
        hreadyout = 1'b1;
        wr_en     = 1'b1;
      end
      RD_CAP:  rd_en = 1'b1;
      RD_WT:   hreadyout = 1'b0;
      RD_DONE: hreadyout = 1'b1;
      ERR1:    hresp = RESP_ERROR;
      ERR2: begin
        hreadyout = 1'b1;
        hresp     = RESP_ERROR;
      end
      default: hreadyout = 1'b0;
    endcase
  end

  // State register; reset drops any in-flight transfer immediately
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read wait-state counter, loaded while the regfile read is captured
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wt_cnt <= 2'd0;
    end else if (state == RD_CAP) begin
      wt_cnt <= WT_LOAD;
    end else if ((state == RD_WT) && (wt_cnt != 2'd0)) begin
      wt_cnt <= wt_cnt - 2'd1;
    end
  end

  // Read data is captured once per read and held until the next capture
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hrdata <= '0;
    end else if (state == RD_CAP) begin
      hrdata <= ihrdata;
    end
  end

  // Routing info of the accepted transfer; an illegal access keeps the old word index
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      reg_addr <= '0;
      reg_mid  <= '0;
    end else if (acc) begin
      reg_mid <= hmaster;
      if (!illegal) begin
        reg_addr <= index;
      end
    end
  end

endmodule

// File: tb/tb_hsem_ahb_biu.sv
// tb/tb_hsem_ahb_biu.sv - randomized self-checking bench for hsem_ahb_biu against a transfer-level model
module tb_hsem_ahb_biu;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 24;
  localparam int MID_W    = 4;
  localparam int RD_WAIT  = 2;
  localparam int PRIV_EN  = 1;

  logic        hclk    = 1'b0;
  logic        hreset  = 1'b1;
  logic        hsel    = 1'b0;
  logic        stall   = 1'b0;
  logic [1:0]  htrans  = 2'b00;
  logic [2:0]  hsize   = 3'd2;
  logic        hwrite  = 1'b0;
  logic [31:0] haddr   = 32'd0;
  logic [3:0]  hprot   = 4'h2;
  logic [3:0]  hmaster = 4'd0;
  logic [31:0] hwdata  = 32'd0;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] ihrdata;
  logic [31:0] ihwdata;
  logic        wr_en;
  logic        rd_en;
  logic [4:0]  reg_addr;
  logic [3:0]  reg_mid;

  always #5 hclk = ~hclk;

  // Single slave on the bus; stall models another bus agent holding hready low
  assign hready = hreadyout & ~stall;

  hsem_ahb_biu #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_REGS(NUM_REGS),
    .MID_W(MID_W), .RD_WAIT(RD_WAIT), .PRIV_EN(PRIV_EN)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready),
    .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .haddr(haddr),
    .hprot(hprot), .hmaster(hmaster), .hwdata(hwdata),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .ihrdata(ihrdata), .ihwdata(ihwdata), .wr_en(wr_en), .rd_en(rd_en),
    .reg_addr(reg_addr), .reg_mid(reg_mid)
  );

  function automatic logic [31:0] preload(input int i);
    return 32'h5EED_0000 ^ (32'(i) * 32'h0101_0111);
  endfunction

  // Simple regfile responder: reloads on reset, read data only meaningful during rd_en
  logic [31:0] regs [32];
  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < 32; i++) regs[i] <= preload(i);
    end else if (wr_en) begin
      regs[reg_addr] <= ihwdata;
    end
  end
  assign ihrdata = rd_en ? regs[reg_addr] : 32'hBAD0_BAD0;

  // Transfer-level model: one expected record per data-phase cycle
  typedef struct packed {
    logic        ready;
    logic [1:0]  resp;
    logic        wr;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [32];
  logic [31:0] exp_hrdata;
  logic [4:0]  exp_reg_addr;
  logic [3:0]  exp_reg_mid;
  logic        pend_wr;
  logic [31:0] pend_wdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic exp_t mk(input logic rdy, input logic [1:0] rsp, input logic w,
                              input logic r, input logic [31:0] d);
    exp_t e;
    e.ready = rdy; e.resp = rsp; e.wr = w; e.rd = r; e.rdata = d;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_hrdata   = 32'd0;
    exp_reg_addr = 5'd0;
    exp_reg_mid  = 4'd0;
    pend_wr      = 1'b0;
    pend_wdata   = 32'd0;
    for (int i = 0; i < 32; i++) model_mem[i] = preload(i);
  endtask

  task automatic check_reset_values();
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp",     32'(hresp),     32'd0);
    chk("rst_wr_en",     32'(wr_en),     32'd0);
    chk("rst_rd_en",     32'(rd_en),     32'd0);
    chk("rst_hrdata",    hrdata,         32'd0);
    chk("rst_reg_addr",  32'(reg_addr),  32'd0);
    chk("rst_reg_mid",   32'(reg_mid),   32'd0);
  endtask

  // One bus cycle: check the current data-phase cycle, then present the next address phase
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [31:0] addr, input logic [2:0] size,
                           input logic [3:0] prot, input logic [3:0] mid,
                           input logic [31:0] wdata, input logic stl,
                           output logic accepted);
    exp_t        e;
    logic [31:0] cur_wd;
    logic [31:0] newv;
    logic        illegal;
    int          idx;
    @(negedge hclk);
    cur_wd  = pend_wdata;
    hwdata  = pend_wr ? pend_wdata : $urandom();
    pend_wr = 1'b0;
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = mk(1'b1, 2'b00, 1'b0, 1'b0, exp_hrdata);
    chk("hreadyout", 32'(hreadyout), 32'(e.ready));
    chk("hresp",     32'(hresp),     32'(e.resp));
    chk("wr_en",     32'(wr_en),     32'(e.wr));
    chk("rd_en",     32'(rd_en),     32'(e.rd));
    chk("hrdata",    hrdata,         e.rdata);
    chk("reg_addr",  32'(reg_addr),  32'(exp_reg_addr));
    chk("reg_mid",   32'(reg_mid),   32'(exp_reg_mid));
    if (e.wr) chk("ihwdata", ihwdata, cur_wd);

    hsel = sel; htrans = trans; hwrite = wr; haddr = addr;
    hsize = size; hprot = prot; hmaster = mid; stall = stl;
    accepted = e.ready && !stl && sel && trans[1];
    if (accepted) begin
      idx     = int'((addr / 32'd4) % 32'd32);
      illegal = (size != 3'd2) || ((addr % 32'd4) != 32'd0) || (idx >= NUM_REGS) ||
                ((PRIV_EN != 0) && !prot[1]);
      exp_reg_mid = mid;
      if (illegal) begin
        exp_q.push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, exp_hrdata));
        exp_q.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, exp_hrdata));
      end else if (wr) begin
        exp_reg_addr   = 5'(idx);
        model_mem[idx] = wdata;
        pend_wr        = 1'b1;
        pend_wdata     = wdata;
        exp_q.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, exp_hrdata));
      end else begin
        exp_reg_addr = 5'(idx);
        newv         = model_mem[idx];
        exp_q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, exp_hrdata));
        for (int k = 0; k < RD_WAIT; k++) exp_q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, newv));
        exp_q.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, newv));
        exp_hrdata = newv;
      end
    end
  endtask

  // Hold one transfer on the bus until it is taken
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [3:0] prot, input logic [3:0] mid,
                       input logic [31:0] wdata, input logic rnd_stall);
    logic taken;
    logic stl;
    taken = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (!taken) begin
        stl = rnd_stall && ($urandom_range(0, 7) == 0);
        bus_cycle(1'b1, 2'b10, wr, addr, size, prot, mid, wdata, stl, taken);
      end
    end
  endtask

  task automatic idle(input int n);
    logic dummy;
    for (int i = 0; i < n; i++)
      bus_cycle(1'b0, 2'b00, 1'b0, 32'd0, 3'd2, 4'h2, 4'd0, 32'd0, 1'b0, dummy);
  endtask

  initial begin
    logic        dummy;
    logic        rw;
    logic [31:0] ra;
    logic [2:0]  rs;
    logic [3:0]  rp;

    model_reset();
    @(negedge hclk);
    #1;
    check_reset_values();
    @(negedge hclk);
    hreset = 1'b0;

    // Basic write then read of the written word
    issue(1'b1, 32'h08, 3'd2, 4'h2, 4'd3, 32'hA5A5_0001, 1'b0);
    idle(1);
    issue(1'b0, 32'h10, 3'd2, 4'h2, 4'd5, 32'd0, 1'b0);
    idle(5);
    issue(1'b0, 32'h08, 3'd2, 4'h3, 4'd6, 32'd0, 1'b0);
    idle(4);

    // Illegal accesses: index at/above NUM_REGS, byte size, misaligned; then the last legal word
    issue(1'b1, 32'h60, 3'd2, 4'h2, 4'd1, 32'h1111_1111, 1'b0);
    issue(1'b1, 32'h04, 3'd0, 4'h2, 4'd2, 32'h2222_2222, 1'b0);
    issue(1'b1, 32'h5E, 3'd2, 4'h2, 4'd3, 32'h3333_3333, 1'b0);
    issue(1'b1, 32'h7C, 3'd2, 4'h2, 4'd4, 32'h4444_4444, 1'b0);
    issue(1'b1, 32'h5C, 3'd2, 4'h2, 4'd7, 32'h5C5C_5C5C, 1'b0);
    issue(1'b0, 32'h5C, 3'd2, 4'h2, 4'd8, 32'd0, 1'b0);
    issue(1'b0, 32'h04, 3'd2, 4'h2, 4'd8, 32'd0, 1'b0);
    idle(4);

    // User-mode read is refused, privileged read of the same word is accepted
    issue(1'b0, 32'h10, 3'd2, 4'h0, 4'd9, 32'd0, 1'b0);
    issue(1'b0, 32'h10, 3'd2, 4'h2, 4'd9, 32'd0, 1'b0);
    idle(4);

    // Back-to-back write, read, write with no idle cycles between
    issue(1'b1, 32'h00, 3'd2, 4'h2, 4'd1, 32'hCAFE_0000, 1'b0);
    issue(1'b0, 32'h04, 3'd2, 4'h2, 4'd2, 32'd0, 1'b0);
    issue(1'b1, 32'h08, 3'd2, 4'h2, 4'd3, 32'hCAFE_0008, 1'b0);
    issue(1'b0, 32'h00, 3'd2, 4'h2, 4'd4, 32'd0, 1'b0);
    issue(1'b0, 32'h08, 3'd2, 4'h2, 4'd4, 32'd0, 1'b0);
    idle(4);

    // Non-starting transfer types and deselected slave must not be taken
    bus_cycle(1'b1, 2'b00, 1'b1, 32'h0C, 3'd2, 4'h2, 4'd11, 32'hDEAD_000C, 1'b0, dummy);
    bus_cycle(1'b1, 2'b01, 1'b1, 32'h0C, 3'd2, 4'h2, 4'd12, 32'hDEAD_000C, 1'b0, dummy);
    bus_cycle(1'b0, 2'b10, 1'b1, 32'h0C, 3'd2, 4'h2, 4'd13, 32'hDEAD_000C, 1'b0, dummy);
    issue(1'b0, 32'h0C, 3'd2, 4'h2, 4'd14, 32'd0, 1'b0);
    idle(4);

    // Reset pulse while the read sits in its wait states
    issue(1'b0, 32'h08, 3'd2, 4'h2, 4'd10, 32'd0, 1'b0);
    idle(2);
    @(negedge hclk);
    hreset = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(negedge hclk);
    #1;
    check_reset_values();
    hreset = 1'b0;
    issue(1'b0, 32'h08, 3'd2, 4'h2, 4'd10, 32'd0, 1'b0);
    idle(5);

    // Randomized traffic with occasional illegal attributes and external stalls
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      rw = 1'($urandom_range(0, 1));
      ra = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) != 0) ra = ra & 32'hFFFF_FFFC;
      rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      rp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) != 0) rp[1] = 1'b1;
      issue(rw, ra, rs, rp, 4'($urandom_range(0, 15)), $urandom(), 1'b1);
    end
    idle(6);
    stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
